comp_col_accum: RTL and testbench

Parametrised, pipelined column compressor. It reduces a WIDTH-bit input column to its population count and optionally accumulates counts across a multi-beat frame. It generalises the fixed 128-bit single-column compressor: configurable width and pipeline depth, a valid-qualified stream, a per-beat single/accumulate mode, and a saturating frame accumulator with overflow flag. It sits between the operand-column generator and the final carry-propagate/reduction logic in the arithmetic datapath.

---
 rtl/comp_pkg.sv | 42 ++++
 rtl/comp_tree_level.sv | 64 ++++++
 rtl/comp_col_accum.sv | 189 ++++++++++++++++++
 tb/tb_comp_col_accum.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types and elaboration-time helpers for the column compressor:
// width math, adder-tree level sizing and pipeline register placement.
package comp_pkg;

  typedef enum logic {
    CM_SINGLE = 1'b0,
    CM_ACCUM  = 1'b1
  } comp_mode_e;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned out_width(input int unsigned w);
    return clog2_f(w + 1);
  endfunction

  function automatic int unsigned tree_levels(input int unsigned w);
    return clog2_f(w);
  endfunction

  // Operand count entering tree level lvl (level 0 sees the raw column bits).
  function automatic int unsigned level_count(input int unsigned w, input int unsigned lvl);
    int unsigned n;
    n = w;
    for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // True when a register stage follows level lvl (1-based): levels floor(k*L/(P+1)), k=1..P.
  function automatic bit is_reg_level(input int unsigned levels, input int unsigned pipe,
                                      input int unsigned lvl);
    for (int unsigned k = 1; k <= pipe; k++) begin
      if ((k * levels) / (pipe + 1) == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/comp_tree_level.sv
// One pairwise-add level of the popcount tree, with an optional register
// stage that carries valid/mode/last alongside the partial sums.
module comp_tree_level #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned W_IN  = 1,
  parameter bit          REG   = 1'b0,
  localparam int unsigned N_OUT = (N_IN + 1) / 2,
  localparam int unsigned W_OUT = W_IN + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_mode,
  input  logic                   in_last,
  input  logic [N_IN*W_IN-1:0]   in_data,
  output logic                   out_valid,
  output logic                   out_mode,
  output logic                   out_last,
  output logic [N_OUT*W_OUT-1:0] out_data
);

  logic [2*N_OUT*W_IN-1:0] pad;
  logic [N_OUT*W_OUT-1:0]  sum_d;

  // An odd operand count is padded with a zero partner.
  always_comb begin
    pad = '0;
    pad[N_IN*W_IN-1:0] = in_data;
    sum_d = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      sum_d[i*W_OUT +: W_OUT] = W_OUT'(pad[(2*i)*W_IN +: W_IN])
                              + W_OUT'(pad[(2*i+1)*W_IN +: W_IN]);
    end
  end

  if (REG) begin : g_reg
    logic                   valid_q;
    logic                   mode_q;
    logic                   last_q;
    logic [N_OUT*W_OUT-1:0] sum_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
      end
      mode_q <= in_mode;
      last_q <= in_last;
      sum_q  <= sum_d;
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_last  = last_q;
    assign out_data  = sum_q;
  end else begin : g_comb
    assign out_valid = in_valid;
    assign out_mode  = in_mode;
    assign out_last  = in_last;
    assign out_data  = sum_d;
  end

endmodule

// File: rtl/comp_col_accum.sv
// Pipelined column popcount with an optional saturating multi-beat frame
// accumulator. Latency: beat -> comp_out in PIPE+2 cycles, -> acc_out in PIPE+3.
module comp_col_accum
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned ACC_W = 16,
  localparam int unsigned OUT_W = out_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_col0,
  output logic             out_valid,
  output logic [OUT_W-1:0] comp_out,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf
);

  localparam int unsigned LEVELS = tree_levels(WIDTH);
  localparam int unsigned TREE_W = LEVELS + 1;

  logic             in_valid_q;
  logic             in_last_q;
  comp_mode_e       in_mode_q;
  logic [WIDTH-1:0] col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
    end
    in_last_q <= in_last;
    in_mode_q <= comp_mode_e'(in_mode);
    col_q     <= in_col0;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned N_IN  = level_count(WIDTH, l);
    localparam int unsigned N_OUT = level_count(WIDTH, l + 1);
    localparam int unsigned W_IN  = l + 1;

    logic                      v_in, m_in, l_in;
    logic                      v_out, m_out, l_out;
    logic [N_IN*W_IN-1:0]      d_in;
    logic [N_OUT*(W_IN+1)-1:0] d_out;

    if (l == 0) begin : g_head
      assign v_in = in_valid_q;
      assign m_in = (in_mode_q == CM_ACCUM);
      assign l_in = in_last_q;
      assign d_in = col_q;
    end else begin : g_link
      assign v_in = g_lvl[l-1].v_out;
      assign m_in = g_lvl[l-1].m_out;
      assign l_in = g_lvl[l-1].l_out;
      assign d_in = g_lvl[l-1].d_out;
    end

    comp_tree_level #(
      .N_IN (N_IN),
      .W_IN (W_IN),
      .REG  (is_reg_level(LEVELS, PIPE, l + 1))
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_in),
      .in_mode   (m_in),
      .in_last   (l_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_mode  (m_out),
      .out_last  (l_out),
      .out_data  (d_out)
    );
  end

  logic              tree_valid;
  logic              tree_mode;
  logic              tree_last;
  logic [TREE_W-1:0] tree_sum;

  assign tree_valid = g_lvl[LEVELS-1].v_out;
  assign tree_mode  = g_lvl[LEVELS-1].m_out;
  assign tree_last  = g_lvl[LEVELS-1].l_out;
  assign tree_sum   = g_lvl[LEVELS-1].d_out;

  logic             out_valid_d, out_valid_q;
  logic             out_last_d, out_last_q;
  comp_mode_e       out_mode_d, out_mode_q;
  logic [OUT_W-1:0] comp_out_d, comp_out_q;

  always_comb begin
    out_valid_d = tree_valid;
    out_last_d  = tree_last;
    out_mode_d  = comp_mode_e'(tree_mode);
    comp_out_d  = tree_valid ? tree_sum[OUT_W-1:0] : comp_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mode_q  <= CM_SINGLE;
      comp_out_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_mode_q  <= out_mode_d;
      comp_out_q  <= comp_out_d;
    end
  end

  logic             beat_acc;
  logic             sat;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] next_sum;
  logic             next_ovf;

  logic [ACC_W-1:0] sum_d, sum_q;
  logic             first_d, first_q;
  logic             ovf_d, ovf_q;
  logic [ACC_W-1:0] acc_out_d, acc_out_q;
  logic             acc_ovf_d, acc_ovf_q;
  logic             acc_valid_d, acc_valid_q;

  // The first beat of a frame overwrites the running sum rather than adding to it,
  // which lets a new frame start on the cycle right after a close.
  always_comb begin
    beat_acc = out_valid_q && (out_mode_q == CM_ACCUM);
    base     = first_q ? '0 : sum_q;
    sum_ext  = {1'b0, base} + (ACC_W+1)'(comp_out_q);
    sat      = sum_ext[ACC_W];
    next_sum = sat ? '1 : sum_ext[ACC_W-1:0];
    next_ovf = ovf_q | sat;

    sum_d       = sum_q;
    first_d     = first_q;
    ovf_d       = ovf_q;
    acc_out_d   = acc_out_q;
    acc_ovf_d   = acc_ovf_q;
    acc_valid_d = 1'b0;

    if (beat_acc) begin
      sum_d = next_sum;
      if (out_last_q) begin
        acc_out_d   = next_sum;
        acc_ovf_d   = next_ovf;
        acc_valid_d = 1'b1;
        first_d     = 1'b1;
        ovf_d       = 1'b0;
      end else begin
        first_d = 1'b0;
        ovf_d   = next_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      acc_out_q   <= acc_out_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign comp_out  = comp_out_q;
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_out_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_comp_col_accum.sv
// Directed bench for comp_col_accum across several width/pipe/acc configurations.
module tb_comp_col_accum;

  logic clk;
  logic rst;
  logic in_valid, in_last, in_mode;
  logic [127:0]  col_a;
  logic [1:0]    col_c;
  logic [126:0]  col_d;
  logic [1023:0] col_e;

  int checks;
  int failures;

  // A: 128/2/16  B: 128/2/8  C: 2/0  D: 127/1  E: 1024/9  F: 128/6
  logic        a_ov, a_av, a_ao; logic [7:0]  a_co; logic [15:0] a_acc;
  logic        b_ov, b_av, b_ao; logic [7:0]  b_co; logic [7:0]  b_acc;
  logic        c_ov, c_av, c_ao; logic [1:0]  c_co; logic [15:0] c_acc;
  logic        d_ov, d_av, d_ao; logic [6:0]  d_co; logic [15:0] d_acc;
  logic        e_ov, e_av, e_ao; logic [10:0] e_co; logic [15:0] e_acc;
  logic        f_ov, f_av, f_ao; logic [7:0]  f_co; logic [15:0] f_acc;

  comp_col_accum #(.WIDTH(128), .PIPE(2), .ACC_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_a), .out_valid(a_ov), .comp_out(a_co), .acc_valid(a_av),
    .acc_out(a_acc), .acc_ovf(a_ao));
  comp_col_accum #(.WIDTH(128), .PIPE(2), .ACC_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_a), .out_valid(b_ov), .comp_out(b_co), .acc_valid(b_av),
    .acc_out(b_acc), .acc_ovf(b_ao));
  comp_col_accum #(.WIDTH(2), .PIPE(0), .ACC_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_c), .out_valid(c_ov), .comp_out(c_co), .acc_valid(c_av),
    .acc_out(c_acc), .acc_ovf(c_ao));
  comp_col_accum #(.WIDTH(127), .PIPE(1), .ACC_W(16)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_d), .out_valid(d_ov), .comp_out(d_co), .acc_valid(d_av),
    .acc_out(d_acc), .acc_ovf(d_ao));
  comp_col_accum #(.WIDTH(1024), .PIPE(9), .ACC_W(16)) u_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_e), .out_valid(e_ov), .comp_out(e_co), .acc_valid(e_av),
    .acc_out(e_acc), .acc_ovf(e_ao));
  comp_col_accum #(.WIDTH(128), .PIPE(6), .ACC_W(16)) u_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_mode(in_mode),
    .in_col0(col_a), .out_valid(f_ov), .comp_out(f_co), .acc_valid(f_av),
    .acc_out(f_acc), .acc_ovf(f_ao));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One ones-beat at cycle 0, idle at 1, zeros-beat at 2; k cycles later.
  task automatic chk_lat(input string tag, input int k, input int p, input int w,
                         input logic ov, input logic [63:0] co);
    logic        ev;
    logic [63:0] ec;
    ev = (k == p + 2) || (k == p + 4);
    ec = (k < p + 2) ? 64'd0 : (k < p + 4) ? 64'(w) : 64'd0;
    chk($sformatf("%s_valid_k%0d", tag, k), ov, ev);
    chk($sformatf("%s_count_k%0d", tag, k), co, ec);
  endtask

  logic [127:0] vec [10];
  int           pc  [10];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
    col_a = '0; col_c = '0; col_d = '0; col_e = '0;

    vec[0] = 128'h0;                                     pc[0] = 0;
    vec[1] = '1;                                         pc[1] = 128;
    vec[2] = 128'h1;                                     pc[2] = 1;
    vec[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0000; pc[3] = 1;
    vec[4] = 128'hFF;                                    pc[4] = 8;
    vec[5] = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000; pc[5] = 64;
    vec[6] = 128'hAAAA_AAAA;                             pc[6] = 16;
    vec[7] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE; pc[7] = 127;
    vec[8] = 128'h8000_0000_0000_0001_8000_0000_0000_0001; pc[8] = 4;
    vec[9] = 128'hF000_0000_0000_0000_0000_0000_0000_0003; pc[9] = 6;

    tick(); tick();
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_comp_out", a_co, 8'd0);
    chk("rst_acc_valid", a_av, 1'b0);
    chk("rst_acc_out", a_acc, 16'd0);
    chk("rst_acc_ovf", a_ao, 1'b0);
    chk("rst_b_acc_out", b_acc, 8'd0);
    rst = 1'b0;
    tick();

    // Latency, hold and all-zero/all-one boundaries in every configuration.
    for (int i = 0; i < 14; i++) begin
      in_mode = 1'b0; in_last = 1'b0;
      if (i == 0) begin
        in_valid = 1'b1; col_a = '1; col_c = '1; col_d = '1; col_e = '1;
      end else if (i == 2) begin
        in_valid = 1'b1; col_a = '0; col_c = '0; col_d = '0; col_e = '0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk_lat("lat_a", i + 1, 2, 128, a_ov, a_co);
      chk_lat("lat_b", i + 1, 2, 128, b_ov, b_co);
      chk_lat("lat_c", i + 1, 0, 2, c_ov, c_co);
      chk_lat("lat_d", i + 1, 1, 127, d_ov, d_co);
      chk_lat("lat_e", i + 1, 9, 1024, e_ov, e_co);
      chk_lat("lat_f", i + 1, 6, 128, f_ov, f_co);
      chk($sformatf("single_no_acc_k%0d", i + 1), a_av, 1'b0);
    end

    // Ten back-to-back single-mode beats with hand-counted popcounts.
    for (int i = 0; i < 15; i++) begin
      int          k;
      logic        ev;
      logic [63:0] ec;
      in_mode = 1'b0; in_last = 1'b0;
      if (i < 10) begin
        in_valid = 1'b1; col_a = vec[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      k  = i + 1;
      ev = (k >= 4) && (k < 14);
      ec = (k < 4) ? 64'd0 : (k < 14) ? 64'(pc[k-4]) : 64'(pc[9]);
      chk($sformatf("stream_valid_k%0d", k), a_ov, ev);
      chk($sformatf("stream_count_k%0d", k), a_co, ec);
    end

    // Frame of 3 x 128 then a back-to-back single-beat frame of 4.
    for (int i = 0; i < 12; i++) begin
      int k;
      in_mode = 1'b1;
      in_valid = (i < 4);
      in_last = (i == 2) || (i == 3);
      col_a = (i == 3) ? 128'hF : '1;
      tick();
      k = i + 1;
      chk($sformatf("frame_a_acc_valid_k%0d", k), a_av, (k == 7) || (k == 8));
      chk($sformatf("frame_b_acc_valid_k%0d", k), b_av, (k == 7) || (k == 8));
      if (k == 7) begin
        chk("frame_a_sum", a_acc, 16'd384);
        chk("frame_a_ovf", a_ao, 1'b0);
        chk("frame_b_sat_sum", b_acc, 8'd255);
        chk("frame_b_sat_ovf", b_ao, 1'b1);
      end
      if (k == 8) begin
        chk("frame2_a_sum", a_acc, 16'd4);
        chk("frame2_a_ovf", a_ao, 1'b0);
        chk("frame2_b_sum", b_acc, 8'd4);
        chk("frame2_b_ovf", b_ao, 1'b0);
      end
      if (k == 11) begin
        chk("frame_a_hold", a_acc, 16'd4);
        chk("frame_b_hold_ovf", b_ao, 1'b0);
      end
    end

    // Open frame with an interleaved single beat, aborted by reset, then a fresh frame.
    for (int i = 0; i < 13; i++) begin
      int k;
      rst = (i == 5);
      in_last = 1'b0;
      in_valid = 1'b0;
      in_mode = 1'b1;
      if (i == 0 || i == 2) begin
        in_valid = 1'b1; col_a = 128'hFFFF_FFFF_FFFF_FFFF;
      end else if (i == 1) begin
        in_valid = 1'b1; in_mode = 1'b0; col_a = '1;
      end else if (i == 7) begin
        in_valid = 1'b1; in_last = 1'b1; col_a = 128'h1F;
      end
      tick();
      k = i + 1;
      chk($sformatf("abort_acc_valid_k%0d", k), a_av, (k == 12));
      if (k == 5) chk("abort_interleave_count", a_co, 8'd128);
      if (k == 6) begin
        chk("abort_rst_out_valid", a_ov, 1'b0);
        chk("abort_rst_comp_out", a_co, 8'd0);
        chk("abort_rst_acc_out", a_acc, 16'd0);
      end
      if (k == 12) begin
        chk("after_abort_sum", a_acc, 16'd5);
        chk("after_abort_ovf", a_ao, 1'b0);
        chk("after_abort_b_sum", b_acc, 8'd5);
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
